// File: rtl/rec_ctrl_if.sv
// Controller-side bundle: I2C configuration sender request and sample-memory port.
// i2c: o_i2c_start is a one-cycle request with o_i2c_dat stable until the sender answers with a one-cycle i_i2c_finished.
interface rec_ctrl_if #(
   parameter int WORD_W = 24,
   parameter int ADDR_W = 20
);
   logic              o_i2c_start;
   logic [WORD_W-1:0] o_i2c_dat;
   logic              i_i2c_finished;
   logic [ADDR_W-1:0] o_addr;
   logic              o_rec_we;
   logic              o_play_re;

   modport master (
      output o_i2c_start, o_i2c_dat, o_addr, o_rec_we, o_play_re,
      input  i_i2c_finished
   );

   modport slave (
      input  o_i2c_start, o_i2c_dat, o_addr, o_rec_we, o_play_re,
      output i_i2c_finished
   );
endinterface

// File: rtl/rec_ctrl.sv
// Audio recorder controller: codec power-up configuration over I2C, then
// record / play / pause / stop sequencing of a sample memory with variable playback speed.
module rec_ctrl #(
   parameter int N_INIT = 6,
   parameter int WORD_W = 24,
   parameter int ADDR_W = 20,
   parameter int SPD_W  = 3
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_power,
   input  logic                     i_rec,
   input  logic                     i_play,
   input  logic                     i_pause,
   input  logic                     i_stop,
   input  logic [SPD_W-1:0]         i_speed,
   input  logic                     i_slow,
   input  logic                     i_sample,
   input  logic [N_INIT*WORD_W-1:0] i_init_data,
   rec_ctrl_if.master               bus,
   output logic [2:0]               o_state,
   output logic                     o_ready,
   output logic [ADDR_W-1:0]        o_end_addr,
   output logic                     o_full,
   output logic                     o_done
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      INIT       = 3'd1,
      INIT_WAIT  = 3'd2,
      STOP       = 3'd3,
      RECORD     = 3'd4,
      REC_PAUSE  = 3'd5,
      PLAY       = 3'd6,
      PLAY_PAUSE = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      CMD_NONE, CMD_STOP, CMD_PAUSE, CMD_REC, CMD_PLAY
   } cmd_t;

   localparam int CNT_W = $clog2(N_INIT + 1);
   localparam int AW1   = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t             state, state_n;
   logic [CNT_W-1:0]   init_cnt, init_cnt_n;
   logic               i2c_start, i2c_start_n;
   logic [WORD_W-1:0]  i2c_dat, i2c_dat_n;
   logic               ready, ready_n;
   logic [ADDR_W-1:0]  addr, addr_n;
   logic [ADDR_W-1:0]  end_addr, end_addr_n;
   logic               full, full_n;
   logic               done, done_n;
   logic               rec_we, rec_we_n;
   logic               play_re, play_re_n;
   logic [SPD_W-1:0]   speed_q, speed_n;
   logic               slow_q, slow_n;
   logic [SPD_W-1:0]   rep_cnt, rep_n;

   cmd_t               cmd;
   logic [WORD_W-1:0]  init_word;
   logic [ADDR_W:0]    step;
   logic [ADDR_W:0]    play_next;
   logic [SPD_W-1:0]   rep_next;
   logic               play_end;
   logic               finishing;

   always_comb begin
      cmd = CMD_NONE;
      if (i_stop)       cmd = CMD_STOP;
      else if (i_pause) cmd = CMD_PAUSE;
      else if (i_rec)   cmd = CMD_REC;
      else if (i_play)  cmd = CMD_PLAY;
   end

   always_comb begin
      init_word = '0;
      for (int k = 0; k < N_INIT; k++) begin
         if (init_cnt == CNT_W'(k)) init_word = i_init_data[k*WORD_W +: WORD_W];
      end
   end

   // Slow mode repeats each address speed+1 times; >= tolerates a speed re-latched below the held count.
   always_comb begin
      if (slow_q) begin
         step     = (rep_cnt >= speed_q) ? AW1'(1) : '0;
         rep_next = (rep_cnt >= speed_q) ? '0 : rep_cnt + 1'b1;
      end else begin
         step     = AW1'(speed_q) + AW1'(1);
         rep_next = '0;
      end
      play_next = {1'b0, addr} + step;
      play_end  = play_next >= {1'b0, end_addr};
      finishing = play_re && play_end;
   end

   always_comb begin
      state_n     = state;
      init_cnt_n  = init_cnt;
      i2c_start_n = 1'b0;
      i2c_dat_n   = i2c_dat;
      ready_n     = ready;
      addr_n      = addr;
      end_addr_n  = end_addr;
      full_n      = full;
      done_n      = 1'b0;
      rec_we_n    = 1'b0;
      play_re_n   = 1'b0;
      speed_n     = speed_q;
      slow_n      = slow_q;
      rep_n       = rep_cnt;

      if (!i_power) begin
         state_n    = IDLE;
         init_cnt_n = '0;
         ready_n    = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state_n    = INIT;
               init_cnt_n = '0;
            end
            INIT: begin
               if (init_cnt < CNT_W'(N_INIT)) begin
                  i2c_dat_n   = init_word;
                  i2c_start_n = 1'b1;
                  state_n     = INIT_WAIT;
               end else begin
                  state_n = STOP;
                  ready_n = 1'b1;
               end
            end
            INIT_WAIT: begin
               if (bus.i_i2c_finished) begin
                  init_cnt_n = init_cnt + 1'b1;
                  state_n    = INIT;
               end
            end
            STOP: begin
               case (cmd)
                  CMD_REC: begin
                     addr_n  = '0;
                     full_n  = 1'b0;
                     state_n = RECORD;
                  end
                  CMD_PLAY: begin
                     if (end_addr != '0) begin
                        addr_n  = '0;
                        speed_n = i_speed;
                        slow_n  = i_slow;
                        rep_n   = '0;
                        state_n = PLAY;
                     end
                  end
                  default: ;
               endcase
            end
            RECORD: begin
               // A write finishing this cycle advances the address even if a command also arrives.
               if (rec_we) begin
                  if (addr == ADDR_MAX) begin
                     full_n     = 1'b1;
                     end_addr_n = ADDR_MAX;
                     state_n    = STOP;
                  end else begin
                     addr_n = addr + 1'b1;
                  end
               end
               if (!(rec_we && addr == ADDR_MAX)) begin
                  case (cmd)
                     CMD_STOP: begin
                        end_addr_n = addr_n;
                        state_n    = STOP;
                     end
                     CMD_PAUSE: state_n  = REC_PAUSE;
                     CMD_NONE:  rec_we_n = i_sample;
                     default: ;
                  endcase
               end
            end
            REC_PAUSE: begin
               case (cmd)
                  CMD_STOP: begin
                     end_addr_n = addr;
                     state_n    = STOP;
                  end
                  CMD_REC: state_n = RECORD;
                  default: ;
               endcase
            end
            PLAY: begin
               if (play_re) begin
                  rep_n = rep_next;
                  if (play_end) begin
                     state_n = STOP;
                     done_n  = 1'b1;
                  end else begin
                     addr_n = play_next[ADDR_W-1:0];
                  end
               end
               case (cmd)
                  CMD_STOP: begin
                     state_n = STOP;
                     done_n  = 1'b0;
                  end
                  CMD_PAUSE: if (!finishing) state_n = PLAY_PAUSE;
                  CMD_NONE:  if (!finishing) play_re_n = i_sample;
                  default: ;
               endcase
            end
            PLAY_PAUSE: begin
               case (cmd)
                  CMD_STOP: state_n = STOP;
                  CMD_PLAY: begin
                     speed_n = i_speed;
                     slow_n  = i_slow;
                     state_n = PLAY;
                  end
                  default: ;
               endcase
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state     <= IDLE;
         init_cnt  <= '0;
         i2c_start <= 1'b0;
         i2c_dat   <= '0;
         ready     <= 1'b0;
         addr      <= '0;
         end_addr  <= '0;
         full      <= 1'b0;
         done      <= 1'b0;
         rec_we    <= 1'b0;
         play_re   <= 1'b0;
         speed_q   <= '0;
         slow_q    <= 1'b0;
         rep_cnt   <= '0;
      end else begin
         state     <= state_n;
         init_cnt  <= init_cnt_n;
         i2c_start <= i2c_start_n;
         i2c_dat   <= i2c_dat_n;
         ready     <= ready_n;
         addr      <= addr_n;
         end_addr  <= end_addr_n;
         full      <= full_n;
         done      <= done_n;
         rec_we    <= rec_we_n;
         play_re   <= play_re_n;
         speed_q   <= speed_n;
         slow_q    <= slow_n;
         rep_cnt   <= rep_n;
      end
   end

   assign bus.o_i2c_start = i2c_start;
   assign bus.o_i2c_dat   = i2c_dat;
   assign bus.o_addr      = addr;
   assign bus.o_rec_we    = rec_we;
   assign bus.o_play_re   = play_re;
   assign o_state         = state;
   assign o_ready         = ready;
   assign o_end_addr      = end_addr;
   assign o_full          = full;
   assign o_done          = done;

endmodule
